// File: rtl/riscv_pkg.sv
// Shared types for the fetch-stage controller: PC mux select encoding and FSM states.
package riscv_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4    = 2'b00,
    PC_REDIRECT = 2'b01
  } pc_src_t;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10
  } fetch_state_t;

  localparam int unsigned PERF_CNT_WIDTH = 32;

endpackage

// File: rtl/fetch_perf_counter.sv
// 32-bit wrapping event counter with enable and synchronous clear.
module fetch_perf_counter
  import riscv_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output logic [PERF_CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: PC stall/select, single registered redirect, IF/ID and ID/EX flushes.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_controller
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ack,
  input  logic             hazard_stall,
  input  logic             branch_e,
  input  logic             zero_e,
  input  logic             jump_e,
  input  logic             jalr_e,
  input  logic [WIDTH-1:0] pc_target_e,
  input  logic [WIDTH-1:0] alu_result_e,
  output logic             imem_req,
  output logic             pc_stall,
  output logic [1:0]       pc_src,
  output logic [WIDTH-1:0] pc_redirect,
  output logic             flush_d,
  output logic             flush_e
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      redirect_cnt
`endif
);

  fetch_state_t     state;
  logic [WIDTH-1:0] pend_tgt;
  logic             take_e;
  logic [WIDTH-1:0] tgt;
  pc_src_t          src;

  assign take_e = jump_e | jalr_e | (branch_e & zero_e);
  // JALR targets are forced halfword-aligned; no misalignment trap is raised.
  assign tgt    = jalr_e ? (alu_result_e & ~WIDTH'(1)) : pc_target_e;
  assign pc_src = src;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pend_tgt <= '0;
    end else begin
      case (state)
        BOOT:  state <= FETCH;
        FETCH: begin
          if (take_e && !imem_ack) begin
            pend_tgt <= tgt;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    pc_stall    = 1'b1;
    src         = PC_PLUS4;
    pc_redirect = '0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    case (state)
      BOOT: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (take_e && imem_ack) begin
          pc_stall    = 1'b0;
          src         = PC_REDIRECT;
          pc_redirect = tgt;
          flush_d     = 1'b1;
          flush_e     = 1'b1;
        end else if (take_e) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (hazard_stall) begin
          flush_e = 1'b1;
        end else if (!imem_ack) begin
          flush_d = 1'b1;
        end else begin
          pc_stall = 1'b0;
        end
      end
      DRAIN: begin
        // EX only holds bubbles here, so branch/jump inputs are deliberately ignored.
        imem_req = 1'b1;
        flush_d  = 1'b1;
        if (imem_ack) begin
          pc_stall    = 1'b0;
          src         = PC_REDIRECT;
          pc_redirect = pend_tgt;
        end
      end
      default: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall_en;
  logic redirect_en;

  assign stall_en    = pc_stall && (state != BOOT);
  assign redirect_en = (src == PC_REDIRECT);

  fetch_perf_counter u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_en),
    .count (stall_cycles)
  );

  fetch_perf_counter u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (redirect_en),
    .count (redirect_cnt)
  );
`else
  // Counters absent: no extra ports or state.
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller; FETCH_PERF_CNT_EN additionally checks the counters.
module tb_fetch_controller;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             imem_ack = 1'b0;
  logic             hazard_stall = 1'b0;
  logic             branch_e = 1'b0;
  logic             zero_e = 1'b0;
  logic             jump_e = 1'b0;
  logic             jalr_e = 1'b0;
  logic [WIDTH-1:0] pc_target_e = '0;
  logic [WIDTH-1:0] alu_result_e = '0;
  logic             imem_req;
  logic             pc_stall;
  logic [1:0]       pc_src;
  logic [WIDTH-1:0] pc_redirect;
  logic             flush_d;
  logic             flush_e;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      redirect_cnt;
`endif

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  fetch_controller #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_ack     (imem_ack),
    .hazard_stall (hazard_stall),
    .branch_e     (branch_e),
    .zero_e       (zero_e),
    .jump_e       (jump_e),
    .jalr_e       (jalr_e),
    .pc_target_e  (pc_target_e),
    .alu_result_e (alu_result_e),
    .imem_req     (imem_req),
    .pc_stall     (pc_stall),
    .pc_src       (pc_src),
    .pc_redirect  (pc_redirect),
    .flush_d      (flush_d),
    .flush_e      (flush_e)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .redirect_cnt (redirect_cnt)
`endif
  );

  typedef struct packed {
    logic rst, ack, hz, br, z, j, jr;
    logic [WIDTH-1:0] tgt, alu;
  } stim_t;

  typedef struct packed {
    logic             req, stall;
    logic [1:0]       src;
    logic [WIDTH-1:0] red;
    logic             fd, fe;
  } obs_t;

  obs_t sb_q[$];

  function automatic stim_t S(input logic r, a, h, b, z, j, jr,
                              input logic [WIDTH-1:0] t, al);
    S = '{rst: r, ack: a, hz: h, br: b, z: z, j: j, jr: jr, tgt: t, alu: al};
  endfunction

  function automatic obs_t E(input logic req, st, input logic [1:0] src,
                             input logic [WIDTH-1:0] red, input logic fd, fe);
    E = '{req: req, stall: st, src: src, red: red, fd: fd, fe: fe};
  endfunction

  function automatic obs_t sample();
    sample = '{req: imem_req, stall: pc_stall, src: pc_src, red: pc_redirect,
               fd: flush_d, fe: flush_e};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    rst          = s.rst;
    imem_ack     = s.ack;
    hazard_stall = s.hz;
    branch_e     = s.br;
    zero_e       = s.z;
    jump_e       = s.j;
    jalr_e       = s.jr;
    pc_target_e  = s.tgt;
    alu_result_e = s.alu;
  endtask

  obs_t boot_o, idle_o;

  task automatic test_reset();
    stim_t st[];
    obs_t  ex[];
    obs_t  got, exp_v;
    st = '{S(1,1,0,0,0,0,0,0,0), S(0,1,0,0,0,0,0,0,0), S(0,1,0,0,0,0,0,0,0)};
    ex = '{boot_o, boot_o, idle_o};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      got = sample();
      exp_v = sb_q.pop_front();
      nchecks++;
      if (got !== exp_v) begin
        nerrors++;
        $display("FAIL reset[%0d] got=%h expected=%h", i, got, exp_v);
      end else $display("reset[%0d] ok outputs=%h", i, got);
    end
  endtask

  task automatic test_jump();
    stim_t st[];
    obs_t  ex[];
    obs_t  got, exp_v;
    st = '{S(0,1,0,0,0,1,0,32'h100,32'h555), S(0,1,0,1,0,0,0,32'h300,0),
           S(0,1,0,0,0,0,0,0,0)};
    ex = '{E(1,0,2'b01,32'h100,1,1), idle_o, idle_o};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      got = sample();
      exp_v = sb_q.pop_front();
      nchecks++;
      if (got !== exp_v) begin
        nerrors++;
        $display("FAIL jump[%0d] got=%h expected=%h", i, got, exp_v);
      end else $display("jump[%0d] ok outputs=%h", i, got);
    end
  endtask

  task automatic test_jalr();
    stim_t st[];
    obs_t  ex[];
    obs_t  got, exp_v;
    st = '{S(0,1,0,0,0,0,1,32'h999,32'h205), S(0,1,0,0,0,0,1,32'h0,32'hFFFF_FFFF),
           S(0,1,0,0,0,0,0,0,0)};
    ex = '{E(1,0,2'b01,32'h204,1,1), E(1,0,2'b01,32'hFFFF_FFFE,1,1), idle_o};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      got = sample();
      exp_v = sb_q.pop_front();
      nchecks++;
      if (got !== exp_v) begin
        nerrors++;
        $display("FAIL jalr[%0d] got=%h expected=%h", i, got, exp_v);
      end else $display("jalr[%0d] ok outputs=%h", i, got);
    end
  endtask

  // Taken branch while memory is busy: one FETCH stall cycle, two DRAIN waits, then redirect.
  task automatic test_branch_drain();
    stim_t st[];
    obs_t  ex[];
    obs_t  got, exp_v;
    st = '{S(0,0,0,1,1,0,0,32'h40,0), S(0,0,0,0,0,1,0,32'h777,0),
           S(0,0,1,1,1,0,0,32'h888,0), S(0,1,0,0,0,0,0,0,0), S(0,1,0,0,0,0,0,0,0)};
    ex = '{E(1,1,2'b00,0,1,1), E(1,1,2'b00,0,1,0), E(1,1,2'b00,0,1,0),
           E(1,0,2'b01,32'h40,1,0), idle_o};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      got = sample();
      exp_v = sb_q.pop_front();
      nchecks++;
      if (got !== exp_v) begin
        nerrors++;
        $display("FAIL branch_drain[%0d] got=%h expected=%h", i, got, exp_v);
      end else $display("branch_drain[%0d] ok outputs=%h", i, got);
    end
  endtask

  task automatic test_hazard();
    stim_t st[];
    obs_t  ex[];
    obs_t  got, exp_v;
    st = '{S(0,1,1,0,0,0,0,0,0), S(0,0,1,0,0,0,0,0,0), S(0,0,0,0,0,0,0,0,0),
           S(0,1,1,0,0,1,0,32'h80,0), S(0,1,0,0,0,0,0,0,0)};
    ex = '{E(1,1,2'b00,0,0,1), E(1,1,2'b00,0,0,1), E(1,1,2'b00,0,1,0),
           E(1,0,2'b01,32'h80,1,1), idle_o};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      got = sample();
      exp_v = sb_q.pop_front();
      nchecks++;
      if (got !== exp_v) begin
        nerrors++;
        $display("FAIL hazard[%0d] got=%h expected=%h", i, got, exp_v);
      end else $display("hazard[%0d] ok outputs=%h", i, got);
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[];
    obs_t  ex[];
    obs_t  got, exp_v;
    st = '{S(0,1,0,0,0,1,0,32'h1000,0), S(0,1,0,1,1,0,0,32'h2000,0),
           S(0,1,0,0,0,0,1,0,32'h3003), S(0,1,0,0,0,0,0,0,0)};
    ex = '{E(1,0,2'b01,32'h1000,1,1), E(1,0,2'b01,32'h2000,1,1),
           E(1,0,2'b01,32'h3002,1,1), idle_o};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      got = sample();
      exp_v = sb_q.pop_front();
      nchecks++;
      if (got !== exp_v) begin
        nerrors++;
        $display("FAIL back_to_back[%0d] got=%h expected=%h", i, got, exp_v);
      end else $display("back_to_back[%0d] ok outputs=%h", i, got);
    end
  endtask

  // Reset while a redirect is pending: the pending target must never appear.
  task automatic test_reset_in_drain();
    stim_t st[];
    obs_t  ex[];
    obs_t  got, exp_v;
    st = '{S(0,0,0,0,0,1,0,32'h5A0,0), S(1,0,0,0,0,0,0,0,0),
           S(0,1,0,0,0,0,0,0,0), S(0,1,0,0,0,0,0,0,0), S(0,1,0,0,0,0,0,0,0)};
    ex = '{E(1,1,2'b00,0,1,1), E(1,1,2'b00,0,1,0), boot_o, idle_o, idle_o};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      got = sample();
      exp_v = sb_q.pop_front();
      nchecks++;
      if (got !== exp_v) begin
        nerrors++;
        $display("FAIL reset_in_drain[%0d] got=%h expected=%h", i, got, exp_v);
      end else $display("reset_in_drain[%0d] ok outputs=%h", i, got);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    stim_t st[];
    obs_t  ex[];
    obs_t  got, exp_v;
    st = '{S(1,1,0,0,0,0,0,0,0), S(0,1,0,0,0,0,0,0,0), S(0,1,0,0,0,0,0,0,0),
           S(0,0,0,1,1,0,0,32'h40,0), S(0,0,0,0,0,0,0,0,0), S(0,0,0,0,0,0,0,0,0),
           S(0,1,0,0,0,0,0,0,0), S(0,1,0,0,0,0,0,0,0)};
    ex = '{E(1,0,2'b00,0,0,0), boot_o, idle_o, E(1,1,2'b00,0,1,1),
           E(1,1,2'b00,0,1,0), E(1,1,2'b00,0,1,0), E(1,0,2'b01,32'h40,1,0), idle_o};
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      got = sample();
      exp_v = sb_q.pop_front();
      nchecks++;
      if (got !== exp_v) begin
        nerrors++;
        $display("FAIL perf_seq[%0d] got=%h expected=%h", i, got, exp_v);
      end else $display("perf_seq[%0d] ok outputs=%h", i, got);
    end
    nchecks++;
    if (redirect_cnt !== 32'd1) begin
      nerrors++;
      $display("FAIL redirect_cnt got=%0d expected=1", redirect_cnt);
    end else $display("redirect_cnt ok = %0d", redirect_cnt);
    nchecks++;
    if (stall_cycles !== 32'd3) begin
      nerrors++;
      $display("FAIL stall_cycles got=%0d expected=3", stall_cycles);
    end else $display("stall_cycles ok = %0d", stall_cycles);
  endtask
`else
  task automatic test_perf();
    $display("perf counters not built");
  endtask
`endif

  initial begin
    boot_o = E(0, 1, 2'b00, 0, 1, 1);
    idle_o = E(1, 0, 2'b00, 0, 0, 0);
    @(posedge clk);
    test_reset();
    test_jump();
    test_jalr();
    test_branch_drain();
    test_hazard();
    test_back_to_back();
    test_reset_in_drain();
    test_perf();
    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
